// File: rtl/bsg_gray_to_binary_rr_server_if.sv
// Bundle of requester-side and consumer-side handshake signals for the
// shared Gray-to-binary conversion server.
interface bsg_gray_to_binary_rr_server_if #(
    parameter int width_p = 32,
    parameter int els_p   = 4
);
    localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [els_p-1:0]         v_i;
    logic [els_p*width_p-1:0] gray_i;
    logic [els_p-1:0]         ready_o;
    logic                     v_o;
    logic [width_p-1:0]       binary_o;
    logic [tag_width_lp-1:0]  tag_o;
    logic                     ready_i;

    // Server side
    modport slave (
        input  v_i, gray_i, ready_i,
        output ready_o, v_o, binary_o, tag_o
    );

    // Environment side: requesters plus result consumer
    modport master (
        output v_i, gray_i, ready_i,
        input  ready_o, v_o, binary_o, tag_o
    );
endinterface

// File: rtl/bsg_gray_to_binary_rr_server.sv
// Round-robin shared Gray-to-binary converter. One requester is granted per
// cycle; its code is converted straight into a single registered output slot
// that can refill in the same cycle it drains.
module bsg_gray_to_binary_rr_server #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_gray_to_binary_rr_server_if.slave bus
);
    localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [tag_width_lp-1:0] last_q, last_d;
    logic [tag_width_lp-1:0] tag_q, tag_d;
    logic [width_p-1:0]      bin_q, bin_d;
    logic                    v_q, v_d;

    logic [els_p-1:0]        grant;
    logic [tag_width_lp-1:0] grant_idx;
    logic                    grant_v;
    logic                    slot_free;
    logic                    hs;
    logic [width_p-1:0]      gray_sel;
    int                      cand_int;
    logic [tag_width_lp-1:0] cand;

    // MSB passes through; every lower bit folds in all bits above it.
    function automatic logic [width_p-1:0] gray2bin(input logic [width_p-1:0] g);
        logic [width_p-1:0] b;
        b = '0;
        b[width_p-1] = g[width_p-1];
        for (int i = width_p - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand_int  = 0;
        cand      = '0;
        for (int o = 1; o <= els_p; o++) begin
            cand_int = (int'(last_q) + o) % els_p;
            cand     = cand_int[tag_width_lp-1:0];
            if (!grant_v && bus.v_i[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot grant and the matching Gray slice
    always_comb begin
        grant    = '0;
        gray_sel = '0;
        for (int k = 0; k < els_p; k++) begin
            if (grant_v && grant_idx == tag_width_lp'(k)) begin
                grant[k] = 1'b1;
                gray_sel = bus.gray_i[k*width_p +: width_p];
            end
        end
    end

    // Slot refills in the cycle it drains, so stalls only come from ready_i
    assign slot_free   = ~v_q | bus.ready_i;
    assign hs          = grant_v & slot_free;
    assign bus.ready_o = grant & {els_p{slot_free}};

    // Next-state: load on handshake, otherwise drain or hold
    always_comb begin
        v_d    = v_q;
        bin_d  = bin_q;
        tag_d  = tag_q;
        last_d = last_q;
        if (hs) begin
            v_d    = 1'b1;
            bin_d  = gray2bin(gray_sel);
            tag_d  = grant_idx;
            last_d = grant_idx;
        end else if (v_q && bus.ready_i) begin
            v_d = 1'b0;
        end
    end

    // State registers; reset points priority at requester 0
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            bin_q  <= '0;
            tag_q  <= '0;
            last_q <= tag_width_lp'(els_p - 1);
        end else begin
            v_q    <= v_d;
            bin_q  <= bin_d;
            tag_q  <= tag_d;
            last_q <= last_d;
        end
    end

    assign bus.v_o      = v_q;
    assign bus.binary_o = bin_q;
    assign bus.tag_o    = tag_q;

    // Requesters must hold v_i until their handshake
    for (genvar k = 0; k < els_p; k++) begin : g_hold
        a_hold_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
            (bus.v_i[k] && !bus.ready_o[k]) |=> bus.v_i[k]);
    end
endmodule

// File: tb/tb_bsg_gray_to_binary_rr_server.sv
// Scoreboard bench: a reference model predicts grants and results at each
// falling edge and queues them; an independent monitor pops and compares
// whenever a result is consumed.
module tb_bsg_gray_to_binary_rr_server;
    localparam int W   = 32;
    localparam int ELS = 4;

    typedef struct {
        logic [W-1:0] bin;
        int           tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rdy = 1'b0;
    logic [ELS-1:0] req_v = '0;
    logic [ELS-1:0] refill = '0;
    logic [W-1:0]   req_g [ELS];

    exp_t q[$];
    bit           mv;
    int           last_m;
    logic [ELS-1:0] hs_m;
    int n_chk = 0;
    int n_pass = 0;

    bsg_gray_to_binary_rr_server_if #(.width_p(W), .els_p(ELS)) bus ();

    bsg_gray_to_binary_rr_server #(.width_p(W), .els_p(ELS)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    assign bus.v_i     = req_v;
    assign bus.ready_i = rdy;
    for (genvar k = 0; k < ELS; k++) begin : g_drv
        assign bus.gray_i[k*W +: W] = req_g[k];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // binary bit i is the parity of all Gray bits at or above i
    function automatic logic [W-1:0] ref_conv(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Reference model: decide this cycle's grant, queue the expected result
    always @(negedge clk) begin : model
        logic [ELS-1:0] er;
        bit sf;
        int g;
        if (reset_n) begin
            er = '0;
            g  = -1;
            sf = !mv || rdy;
            if (sf)
                for (int o = 1; o <= ELS; o++)
                    if (g < 0 && req_v[(last_m + o) % ELS]) g = (last_m + o) % ELS;
            if (g >= 0) begin
                er[g] = 1'b1;
                q.push_back('{bin: ref_conv(req_g[g]), tag: g});
                last_m = g;
                mv = 1'b1;
            end else if (sf) begin
                mv = 1'b0;
            end
            hs_m = er;
            chk("ready_o", 64'(bus.ready_o), 64'(er));
        end
    end

    // Monitor: compare every consumed result against the queue head
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && bus.v_o && rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(bus.tag_o), 64'hDEAD);
            end else begin
                e = q.pop_front();
                chk("binary_o", 64'(bus.binary_o), 64'(e.bin));
                chk("tag_o", 64'(bus.tag_o), 64'(e.tag));
            end
        end
    end

    task automatic reset_on();
        reset_n = 1'b0;
        q.delete();
        mv = 1'b0;
        last_m = ELS - 1;
        hs_m = '0;
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Advance one cycle; retire handshaken requests, optionally re-requesting
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < ELS; k++)
            if (hs_m[k]) begin
                req_v[k] = refill[k];
                req_g[k] = $urandom;
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < ELS; k++) req_g[k] = '0;
        reset_on();
        #2;
        chk("reset_v_o", 64'(bus.v_o), 64'h0);
        chk("reset_binary_o", 64'(bus.binary_o), 64'h0);
        chk("reset_tag_o", 64'(bus.tag_o), 64'h0);
        reset_off();

        // Single request
        req_g[0] = 32'h0000_0003; req_v = 4'b0001; rdy = 1'b1;
        cycle();
        chk("single_v", 64'(bus.v_o), 64'h1);
        chk("single_bin", 64'(bus.binary_o), 64'h2);
        chk("single_tag", 64'(bus.tag_o), 64'h0);

        // Extreme codes
        req_g[2] = 32'h8000_0000; req_v[2] = 1'b1;
        cycle();
        chk("ext_msb_bin", 64'(bus.binary_o), 64'hFFFF_FFFF);
        chk("ext_msb_tag", 64'(bus.tag_o), 64'h2);
        req_g[1] = 32'hFFFF_FFFF; req_v[1] = 1'b1;
        cycle();
        chk("ext_ones_bin", 64'(bus.binary_o), 64'hAAAA_AAAA);
        chk("ext_ones_tag", 64'(bus.tag_o), 64'h1);

        // Round-robin with all requesters continuously active
        reset_on();
        for (int k = 0; k < ELS; k++) req_g[k] = $urandom;
        req_v = '1; refill = '1;
        reset_off();
        for (int n = 0; n < 6; n++) begin
            cycle();
            chk("rr_tag", 64'(bus.tag_o), 64'(n % ELS));
            chk("rr_v", 64'(bus.v_o), 64'h1);
        end

        // Backpressure holds the slot and blocks all grants
        rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("stall_ready_o", 64'(bus.ready_o), 64'h0);
            chk("stall_tag", 64'(bus.tag_o), 64'h1);
            chk("stall_bin", 64'(bus.binary_o), 64'(q[0].bin));
        end
        refill = '0; rdy = 1'b1;
        #1 chk("unstall_grant", 64'(bus.ready_o), 64'b0100);
        cycle();
        chk("unstall_tag", 64'(bus.tag_o), 64'h2);

        // Drain without refill, then a lone request from requester 3
        for (int i = 0; i < 10 && req_v != 0; i++) cycle();
        cycle();
        chk("drain_v", 64'(bus.v_o), 64'h0);
        req_g[3] = 32'h0000_0006; req_v[3] = 1'b1;
        cycle();
        chk("req3_tag", 64'(bus.tag_o), 64'h3);
        chk("req3_bin", 64'(bus.binary_o), 64'h4);

        // Asynchronous reset between edges while a result is pending
        #1 chk("pre_reset_v", 64'(bus.v_o), 64'h1);
        reset_on();
        #1;
        chk("async_v", 64'(bus.v_o), 64'h0);
        chk("async_tag", 64'(bus.tag_o), 64'h0);
        req_g[1] = $urandom; req_g[3] = $urandom;
        req_v = 4'b1010;
        reset_off();
        cycle();
        chk("post_reset_first", 64'(bus.tag_o), 64'h1);
        cycle();
        chk("post_reset_second", 64'(bus.tag_o), 64'h3);

        // Randomised traffic with random consumer backpressure
        for (int n = 0; n < 500; n++) begin
            cycle();
            rdy = ($urandom % 4) != 0;
            for (int k = 0; k < ELS; k++) begin
                refill[k] = $urandom % 2;
                if (!req_v[k] && ($urandom % 3) == 0) begin
                    req_v[k] = 1'b1;
                    req_g[k] = $urandom;
                end
            end
        end
        refill = '0; rdy = 1'b1;
        for (int i = 0; i < 50 && (req_v != 0 || q.size() != 0); i++) cycle();
        cycle();
        chk("leftover_results", 64'(q.size()), 64'h0);
        chk("final_v", 64'(bus.v_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bsg_gray_to_binary_rr_server.md
Name: bsg_gray_to_binary_rr_server

Overview:
- Shared Gray-to-binary conversion server for els_p requesters, each presenting a width_p-bit Gray code under a valid/ready handshake.
- A round-robin arbiter picks one requester per cycle and converts its code into a registered output slot.
- The result leaves on a valid/ready output, tagged with the requester index.
- Used where several Gray-coded pointers/counters (e.g. async FIFO pointers already synchronised into this domain) need binary values but only one converter is affordable.

Parameters:
- width_p, 32, width of each Gray code and of the binary result; must be >= 1.
- els_p, 4, number of requesters; must be >= 2.
- tag_width_lp, max(1, clog2(els_p)), derived, not overridable; width of tag_o.

Ports:
- clk_i  input  1  sole clock; all state updates on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset; assertion clears state immediately; deassertion is synchronised externally.
- v_i  input  els_p  per-requester valid.
- gray_i  input  els_p*width_p  requester k's code in bits [k*width_p +: width_p].
- ready_o  output  els_p  per-requester accept; a handshake occurs when v_i[k] and ready_o[k] are both high.
- v_o  output  1  output slot holds a result.
- binary_o  output  width_p  converted value.
- tag_o  output  tag_width_lp  index of the requester that produced binary_o.
- ready_i  input  1  consumer accepts the result when v_o and ready_i are both high.

Behaviour:
- Reset state (async, while reset_n_i = 0):
  - v_o = 0, binary_o = 0, tag_o = 0.
  - Last-grant pointer last_r = els_p-1, so requester 0 has top priority after reset.
- Conversion:
  - binary[width_p-1] = gray[width_p-1].
  - binary[i] = gray[i] ^ binary[i+1], for i = width_p-2 down to 0.
  - Equivalently, binary[i] is the XOR of gray[width_p-1:i]. Purely combinational into the output register.
- Slot free condition: slot_free = ~v_o | ready_i. The output slot can be refilled in the same cycle it drains, which sustains 1 conversion per cycle.
- Arbitration (combinational):
  - Search starts at last_r+1 and wraps modulo els_p.
  - Grant goes to the first index with v_i set; at most one grant bit is high.
- ready_o[k] = grant[k] & slot_free. ready_o never asserts for a requester whose v_i is low.
- On a handshake with requester k, at the next edge:
  - binary_o <= convert(gray_i slice k).
  - tag_o <= k.
  - v_o <= 1.
  - last_r <= k.
- No handshake, and v_o & ready_i: v_o <= 0. binary_o and tag_o hold their stale values; they are don't-care while v_o = 0.
- No handshake, and v_o & ~ready_i: all state holds. Stall: every ready_o is 0, and binary_o/tag_o stay stable until consumed.
- Latency: 1 cycle from handshake to v_o.
- last_r advances only on a handshake. Requests that are stalled do not rotate priority.
- Requester protocol: v_i[k] and its gray_i slice stay stable until the handshake. Dropping v_i early is illegal; it is covered by an assertion, not handled in logic.
- Simultaneous output drain and new accept in the same cycle: the new result replaces the old one, and v_o stays 1.
- Reset mid-operation:
  - Any pending result is discarded, and v_o falls without waiting for a clock.
  - After release, arbitration restarts with requester 0 as top priority.
- No internal FIFO. Throughput is 1 result per cycle when ready_i is held high.

Test Plan:
- Single request: reset, v_i=4'b0001, gray slice 0 = 32'h0000_0003, ready_i=1 -> ready_o=4'b0001 for one cycle; next cycle v_o=1, binary_o=32'h0000_0002, tag_o=0.
- Extreme values:
  - gray 32'h8000_0000 from requester 2 -> binary_o=32'hFFFF_FFFF, tag_o=2.
  - gray 32'hFFFF_FFFF from requester 1 -> binary_o=32'hAAAA_AAAA, tag_o=1.
- Round-robin: all four v_i held high with ready_i=1 from reset -> grants 0,1,2,3,0,1 on consecutive cycles; tag_o follows one cycle later, and v_o stays high continuously.
- Backpressure: v_o=1, tag_o=1, ready_i=0 for 3 cycles with v_i=4'b1111 -> ready_o=0 and binary_o/tag_o unchanged for all 3 cycles; raising ready_i -> grant 2 in the same cycle, tag_o=2 on the next cycle.
- Drain without refill: v_o=1, v_i=0, ready_i=1 -> v_o=0 next cycle; a later request from requester 3 gives tag_o=3 and the correct conversion.
- Async reset mid-stream: pull reset_n_i low between clock edges while v_o=1 -> v_o=0 immediately; after release with v_i=4'b1010, first grant goes to requester 1, then requester 3.
